// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM stage. A word-addressed SRAM
// with a fixed access latency. The pipeline is held with `stall` until the
// access completes. Load data is presented combinationally in the completion
// cycle so that the MEM/WB register captures it on that edge.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two, at least 2)
//   LATENCY    access wait cycles (>= 1); an access occupies LATENCY+1 cycles
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous reset, active low
//   mem_read    in   load request (held stable by the pipeline while stalled)
//   mem_write   in   store request (wins over mem_read when both are set)
//   addr        in   byte address; word index is addr[log2(DEPTH)+1:2]
//   write_data  in   store data
//   read_data   out  load data in the completion cycle of a load, else 0
//   stall       out  freeze the pipeline
//   done        out  completion-cycle pulse
//   err         out  misaligned request seen in IDLE
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  // Counter only ever holds LATENCY-1, so clog2(LATENCY) bits are enough.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_op_write;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_aligned;
  logic            w_accept;
  logic            w_complete;
  logic [AW-1:0]   w_idx;
  logic            w_unused;

  assign w_req      = mem_read | mem_write;
  assign w_aligned  = (addr[1:0] == 2'b00);
  assign w_idx      = addr[AW+1:2];
  assign w_accept   = (r_state == ST_IDLE) && w_req && w_aligned;
  assign w_complete = (r_state == ST_BUSY) && (r_cnt == '0);

  // Address bits above the word index are don't-care: addresses wrap.
  assign w_unused   = ^{addr[31:AW+2]};

  // Next state and all outputs. Outputs are forced low while reset is held,
  // independent of whatever request the pipeline is presenting.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    stall        = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    read_data    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_aligned) begin
            stall        = 1'b1;
            w_state_next = ST_BUSY;
            w_cnt_next   = CNT_INIT;
          end else begin
            // Misaligned: flag it and let the pipeline move on.
            err = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          stall      = 1'b1;
          w_cnt_next = r_cnt - CW'(1);
        end else begin
          done         = 1'b1;
          w_state_next = ST_IDLE;
          if (!r_op_write) begin
            read_data = r_rdata;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (!RST) begin
      stall     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      read_data = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        // A simultaneous read+write is a store.
        r_op_write <= mem_write;
        r_idx      <= w_idx;
        r_wdata    <= write_data;
      end
    end
  end

  // Storage array, not reset. The read port is registered: the word is
  // sampled on the accept edge, which is never earlier than the commit of
  // a preceding store, so a back-to-back load sees the new data and holds
  // it until its completion cycle. A store can only reach its commit edge
  // with reset deasserted, since reset returns the FSM to IDLE immediately.
  always_ff @(posedge CLK) begin
    if (w_complete && r_op_write) begin
      r_mem[r_idx] <= r_wdata;
    end
    if (r_state == ST_IDLE) begin
      r_rdata <= r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (LATENCY 1, 2, 5; DEPTH 256) exercised one at a time with
// directed and randomized loads/stores. Expected outputs come from a word
// array model indexed by (addr / 4) mod 256 and the cycle-count timing rule:
// stall in cycles 0..L-1, done in cycle L, read data only in the done cycle.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       s_rd;
  logic [2:0]       s_wr;
  logic [2:0][31:0] s_addr;
  logic [2:0][31:0] s_wdata;
  wire  [2:0][31:0] s_rdata;
  wire  [2:0]       s_stall;
  wire  [2:0]       s_done;
  wire  [2:0]       s_err;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH   (256),
        .LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 2 : 5))
      ) u_dut (
        .CLK        (clk),
        .RST        (rst_n),
        .mem_read   (s_rd[gi]),
        .mem_write  (s_wr[gi]),
        .addr       (s_addr[gi]),
        .write_data (s_wdata[gi]),
        .read_data  (s_rdata[gi]),
        .stall      (s_stall[gi]),
        .done       (s_done[gi]),
        .err        (s_err[gi])
      );
    end
  endgenerate

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model   [3][256];
  bit          written [3][256];

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic check_quiet(input int k, input string tag);
    check_value({tag, "_flags"}, {29'b0, s_stall[k], s_done[k], s_err[k]}, 32'h0);
    check_value({tag, "_rdata"}, s_rdata[k], 32'h0);
  endtask

  // One full access starting at a negedge; returns at the negedge after done.
  task automatic access(input int k, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
    int          lat = lat_of(k);
    logic [31:0] exp_rd;
    s_rd[k]    = r;
    s_wr[k]    = w;
    s_addr[k]  = a;
    s_wdata[k] = d;
    exp_rd     = w ? 32'h0 : model[k][widx(a)];
    for (int c = 0; c <= lat; c++) begin
      #2;
      check_value("stall", {31'b0, s_stall[k]}, {31'b0, (c < lat)});
      check_value("done",  {31'b0, s_done[k]},  {31'b0, (c == lat)});
      check_value("err",   {31'b0, s_err[k]},   32'h0);
      check_value("rdata", s_rdata[k], (c == lat) ? exp_rd : 32'h0);
      @(negedge clk);
    end
    if (w) begin
      model[k][widx(a)]   = d;
      written[k][widx(a)] = 1'b1;
    end
    $display("txn lat=%0d %s addr=%h wdata=%h exp_rdata=%h", lat,
             w ? "store" : "load ", a, d, exp_rd);
    s_rd[k] = 1'b0;
    s_wr[k] = 1'b0;
  endtask

  task automatic misaligned(input int k, input logic [31:0] a);
    s_rd[k]   = 1'b1;
    s_wr[k]   = 1'b0;
    s_addr[k] = a;
    #2;
    check_value("mis_err",   {31'b0, s_err[k]},   32'h1);
    check_value("mis_stall", {31'b0, s_stall[k]}, 32'h0);
    check_value("mis_done",  {31'b0, s_done[k]},  32'h0);
    check_value("mis_rdata", s_rdata[k], 32'h0);
    @(negedge clk);
    s_rd[k] = 1'b0;
    #2;
    check_quiet(k, "mis_after");
    @(negedge clk);
    $display("txn lat=%0d misaligned addr=%h", lat_of(k), a);
  endtask

  task automatic idle_cycle(input int k);
    #2;
    check_quiet(k, "idle");
    @(negedge clk);
  endtask

  task automatic reset_mid_store(input int k);
    access(k, 1'b1, 1'b0, 32'h30, 32'h1111_1111);
    s_wr[k]    = 1'b1;
    s_rd[k]    = 1'b0;
    s_addr[k]  = 32'h30;
    s_wdata[k] = 32'hAAAA_5555;
    #2;
    check_value("rst_c0_stall", {31'b0, s_stall[k]}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_quiet(k, "rst_c1");
    @(negedge clk);
    // Pipeline now presents a load of the same word, held across release.
    s_wr[k] = 1'b0;
    s_rd[k] = 1'b1;
    #2;
    check_quiet(k, "rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn lat=%0d reset during store addr=%h", lat_of(k), 32'h30);
    access(k, 1'b0, 1'b1, 32'h30, 32'h0);
  endtask

  task automatic random_ops(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      int          sel;
      a   = {20'($urandom_range(0, 3)), 12'h0} | (32'($urandom_range(0, 15)) << 2);
      a   = a | (32'($urandom_range(0, 3)) << 10);
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        misaligned(k, a | 32'($urandom_range(1, 3)));
      end else if (sel <= 3) begin
        access(k, 1'b1, 1'b0, a, d);
      end else if (sel == 4) begin
        access(k, 1'b1, 1'b1, a, d);
      end else if (written[k][widx(a)]) begin
        access(k, 1'b0, 1'b1, a, d);
      end else begin
        access(k, 1'b1, 1'b0, a, d);
      end
      if ($urandom_range(0, 1) == 1) begin
        idle_cycle(k);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    s_rd    = '0;
    s_wr    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 256; j++) begin
        written[k][j] = 1'b0;
      end
    end
    @(negedge clk);
    // Request presented during reset must be masked on every output.
    s_rd[1]   = 1'b1;
    s_addr[1] = 32'h10;
    #2;
    check_quiet(1, "reset");
    check_quiet(0, "reset");
    @(negedge clk);
    s_rd[1] = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      idle_cycle(k);
      access(k, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
      idle_cycle(k);
      access(k, 1'b0, 1'b1, 32'h10, 32'h0);
      access(k, 1'b0, 1'b1, 32'h10, 32'h0);
      misaligned(k, 32'h13);
      access(k, 1'b0, 1'b1, 32'h10, 32'h0);
      access(k, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
      access(k, 1'b0, 1'b1, 32'h20, 32'h0);
      access(k, 1'b1, 1'b0, 32'h400, 32'hCAFE_0000 | 32'(k));
      access(k, 1'b0, 1'b1, 32'h0, 32'h0);
      reset_mid_store(k);
      random_ops(k, 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the load/store requests issued by the pipeline's MEM stage. It replaces the single-cycle data memory with a word-addressed SRAM model that has a configurable access latency. It holds the pipeline with `stall` until each access completes, and presents load data combinationally in the completion cycle so the MEM/WB register captures it on that edge.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words. Must be a power of two.
- `LATENCY`, default 2: access wait cycles. Must be ≥1.

Ports:
- `CLK` in 1: clock, rising-edge.
- `RST` in 1: reset, asynchronous, active-low.
- `mem_read` in 1: load request. Held stable by the pipeline while `stall`=1.
- `mem_write` in 1: store request. Held stable while `stall`=1.
- `addr` in 32: byte address. The word index is `addr[log2(DEPTH)+1:2]`.
- `write_data` in 32: store data.
- `read_data` out 32: load data. Valid only while `done`=1 on a load; 0 at all other times.
- `stall` out 1: freeze the pipeline.
- `done` out 1: completion cycle (combinational pulse).
- `err` out 1: misaligned request (combinational).

## Operation
- States:
  - IDLE.
  - BUSY, with a down-counter `cnt` (width ≥ clog2(LATENCY)). Latched `op`, `addr_q`, `wdata_q`.
- A request is `req = mem_read | mem_write`. If both are set, it is treated as a store; the read is ignored.
- IDLE, with `req` and `addr[1:0]`=0:
  - `stall`=1.
  - At the edge: latch op/addr/data, set `cnt`=LATENCY-1, go to BUSY.
- IDLE, with `req` and `addr[1:0]`≠0 (misaligned):
  - `err`=1, `stall`=0, `done`=0, `read_data`=0.
  - No state change and no array write.
- IDLE, no `req`: all outputs are 0.
- BUSY with `cnt`≠0: `stall`=1 and `cnt` decrements each edge.
- BUSY with `cnt`=0 (completion cycle):
  - `stall`=0, `done`=1.
  - On a load, `read_data` = array[`addr_q` index].
  - At the edge: a store writes `wdata_q` to the array. Go to IDLE.
- Request inputs are ignored while BUSY. Addresses wrap modulo DEPTH words.
- Array contents are not affected by reset. Reading an unwritten word returns X; the bench must write before reading.
- A load that immediately follows a store to the same word (back-to-back requests) returns the new data, because the store commits at its completion edge.

## Timing
- A request first visible in cycle 0 gets:
  - `stall`=1 in cycles 0..LATENCY-1.
  - `done`=1 and `stall`=0 in cycle LATENCY.
  - Occupancy of LATENCY+1 cycles.
- Throughput: one access per LATENCY+1 cycles. The next request can enter IDLE in the cycle after `done`.
- `stall`, `done`, `err`, and `read_data` are combinational from the state and the inputs. There is no registered output delay.
- Reset (`RST`=0) at any time:
  - State goes to IDLE and `cnt` to 0.
  - All outputs are 0 for as long as `RST`=0, regardless of `req`.
  - An in-flight store is aborted and the array is unchanged.
- Reset deassertion takes effect immediately. A request held at release is accepted at the first edge after release.

## Test plan
- Store then load, LATENCY=2:
  - Store addr 0x10 with data 0xDEADBEEF: `stall` high for 2 cycles, `done` in cycle 2.
  - Load 0x10: `read_data`=0xDEADBEEF in its `done` cycle, 0 otherwise.
- LATENCY=1 and LATENCY=5 sweep: stall lengths of 1 and 5 cycles respectively, `done` exactly one cycle, back-to-back loads each take LATENCY+1 cycles.
- Misaligned load at 0x13: `err`=1 and `stall`=0 in the same cycle, `read_data`=0. A subsequent load of 0x10 still returns the earlier value.
- Simultaneous `mem_read`+`mem_write` at 0x20 with data 0x12345678: behaves as a store. A later load of 0x20 returns 0x12345678.
- Reset mid-store:
  - Store 0xAAAA5555 to 0x30 over prior data 0x11111111, with `RST` low in cycle 1.
  - `stall`/`done` drop to 0 immediately.
  - After release, a load of 0x30 returns 0x11111111.
- Wrap: with DEPTH=256, a store to 0x400 (word 256) followed by a load of 0x0 returns the stored value.
